pipeline_scoreboard: RTL and testbench
======================================

Name: pipeline_scoreboard

Overview:
Parametrised hazard and forwarding unit for the in-order RISC-V pipeline, generalised to any pipeline depth after Decode. It tracks in-flight destination registers and per-instruction result latency in an internal shift register (stage 0 = Execute … STAGES-1 = Writeback). From that state it generates load-use stalls, branch flushes, Execute-stage operand forwarding selects and a stall performance counter. It sits beside the datapath and replaces fixed E/M/W compare logic.

Parameters:
REG_AW, 5, register address width
STAGES, 3, tracked stages after Decode (min 2)
STG_W, $clog2(STAGES), width of stage-index fields (min 1)
CNT_W, 32, stall counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
issue_valid_d  in  1  Decode holds a real instruction
rs1_d  in  REG_AW  Decode source 1
rs2_d  in  REG_AW  Decode source 2
rd_d  in  REG_AW  Decode destination
reg_write_d  in  1  Decode instruction writes rd
ready_at_d  in  STG_W  stage index where result becomes forwardable (ALU=1, load=2)
branch_taken_e  in  1  taken branch/jump resolved in Execute
hold  in  1  global freeze (memory wait)
stall_f  out  1  hold PC
stall_d  out  1  hold F/D register
flush_d  out  1  clear F/D register
bubble_e  out  1  clear D/E register
fwd_a_e  out  STG_W  Execute rs1 source: 0 = register file, s = stage s
fwd_b_e  out  STG_W  Execute rs2 source, same encoding
hazard_error  out  1  sticky: E consumer matched a producer not yet ready
stall_count  out  CNT_W  saturating count of load-use stall cycles

Behaviour:
- Entry per stage: v, rd, wr, ready_at; stage 0 additionally stores rs1 and rs2.
- "Match" means v & wr & rd != 0 & rd == rs. Youngest match (lowest stage index) wins; older matches are ignored.
- ready_at_d = 0 is treated as 1; values above STAGES-1 clamp to STAGES-1.
- Load-use stall (lu): for rs1_d or rs2_d, the youngest match at stage s (0..STAGES-2) with s+1 < ready_at. Gated by issue_valid_d.
- Forwarding (combinational): for stage-0 rs1/rs2, the youngest match at stage s in 1..STAGES-1.
  - If s >= ready_at, fwd = s.
  - Otherwise fwd = 0 and hazard_error is set on the next edge.
  - No match gives fwd = 0.
  - Stage 0 must not match its own rd.
- Priority per cycle: hold > branch_taken_e > lu > normal.
  - hold: stall_f = stall_d = 1, flush_d = bubble_e = 0. No state, counter or error update.
  - branch: flush_d = 1, bubble_e = 1, stall_f = stall_d = 0. lu is ignored and not counted.
  - lu: stall_f = stall_d = 1, bubble_e = 1, stall_count += 1 (saturates at all-ones).
  - normal: all four control outputs are 0.
- Shift on each non-hold edge:
  - Stage s takes stage s-1 for s >= 1; stage STAGES-1 retires.
  - Stage 0 loads the Decode fields if issue_valid_d & !bubble_e; otherwise it gets v = 0.
- Latency: a producer issued at edge N occupies stage k after edge N+1+k.
- Reset (asserted low, any time, including mid-stall or mid-hold) clears immediately:
  - all v = 0, stall_count = 0, hazard_error = 0;
  - outputs follow combinationally: stall_f, stall_d, flush_d, bubble_e = 0; fwd = 0.
- Register-file write-through for Writeback-vs-Decode is the register file's responsibility and is not scored here.

Decomposition:
- Shared package/header pipeline_pkg:
  - FWD_RF = 0;
  - ALU_READY = 1, LOAD_READY = 2;
  - entry field widths/offsets.
- One sub-module, scoreboard_match: combinational youngest-match priority finder.
  - Inputs: rs plus all entries.
  - Outputs: hit, stage index, ready_at.
  - Instantiated four times: D rs1, D rs2, E rs1, E rs2.

Test Plan:
- ALU chain: add x5 (ready 1), then add x6, x5, x1 on the next cycle -> no stall; fwd_a_e = 1 while the consumer is in stage 0.
- Load-use: lw x6 (ready 2), then sub x7, x6, x6 -> one cycle of stall_f = stall_d = bubble_e = 1, stall_count = 1; then fwd_a_e = fwd_b_e = 2, hazard_error = 0.
- Youngest wins and x0: two writes to x7 back-to-back, then a consumer -> fwd = 1. Producer with rd = x0 (ready 2) and consumer of x0 -> no stall, fwd = 0.
- Simultaneous branch and lu: branch_taken_e = 1 while a load-use hazard is present -> flush_d = bubble_e = 1, stall_d = 0, stall_count unchanged.
- Hold: hold = 1 for 3 cycles with lw in stage 0 -> entries frozen, stall_count unchanged; after release the stall occurs exactly once.
- Reset mid-stall, and STAGES = 5 instance: reset low during lu -> all outputs 0 and counter 0 asynchronously. In the STAGES = 5 instance, a ready_at 4 producer followed by a dependent consumer -> 3 stall cycles, then fwd = 4.

Source files
------------

// File: rtl/pipeline_scoreboard_pkg.sv
// Shared constants, entry layout helpers and control-mode encoding for the
// pipeline hazard/forwarding scoreboard.
package pipeline_scoreboard_pkg;

  localparam int FWD_RF     = 0;
  localparam int ALU_READY  = 1;
  localparam int LOAD_READY = 2;

  // Flattened entry layout: {ready_at, rd, wr, v} with v in bit 0.
  localparam int ENT_V_OFF  = 0;
  localparam int ENT_WR_OFF = 1;
  localparam int ENT_RD_OFF = 2;

  function automatic int ent_rdy_off(input int aw);
    return ENT_RD_OFF + aw;
  endfunction

  function automatic int ent_w(input int aw, input int sw);
    return ENT_RD_OFF + aw + sw;
  endfunction

  typedef enum logic [1:0] {
    CTL_NORMAL,
    CTL_LU,
    CTL_BRANCH,
    CTL_HOLD
  } ctl_mode_e;

endpackage

// File: rtl/pipeline_scoreboard_if.sv
// Decode/Execute-side signals exchanged between the pipeline datapath (master)
// and the hazard/forwarding scoreboard (slave).
interface pipeline_scoreboard_if #(
  parameter int REG_AW = 5,
  parameter int STG_W  = 2,
  parameter int CNT_W  = 32
);
  logic              issue_valid_d;
  logic [REG_AW-1:0] rs1_d;
  logic [REG_AW-1:0] rs2_d;
  logic [REG_AW-1:0] rd_d;
  logic              reg_write_d;
  logic [STG_W-1:0]  ready_at_d;
  logic              branch_taken_e;
  logic              hold;
  logic              stall_f;
  logic              stall_d;
  logic              flush_d;
  logic              bubble_e;
  logic [STG_W-1:0]  fwd_a_e;
  logic [STG_W-1:0]  fwd_b_e;
  logic              hazard_error;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output issue_valid_d, rs1_d, rs2_d, rd_d, reg_write_d, ready_at_d,
           branch_taken_e, hold,
    input  stall_f, stall_d, flush_d, bubble_e, fwd_a_e, fwd_b_e,
           hazard_error, stall_count
  );

  modport slave (
    input  issue_valid_d, rs1_d, rs2_d, rd_d, reg_write_d, ready_at_d,
           branch_taken_e, hold,
    output stall_f, stall_d, flush_d, bubble_e, fwd_a_e, fwd_b_e,
           hazard_error, stall_count
  );
endinterface

// File: rtl/pipeline_scoreboard_match.sv
// Youngest-match priority finder: returns the lowest stage index at or above
// FIRST whose valid, writing, non-x0 destination equals rs.
module pipeline_scoreboard_match
  import pipeline_scoreboard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int STAGES = 3,
  parameter int STG_W  = 2,
  parameter int FIRST  = 0
) (
  input  logic [REG_AW-1:0]                          rs,
  input  logic [STAGES*ent_w(REG_AW, STG_W)-1:0]     entries,
  output logic                                       hit,
  output logic [STG_W-1:0]                           stage,
  output logic [STG_W-1:0]                           ready_at
);

  localparam int ENT_W   = ent_w(REG_AW, STG_W);
  localparam int RDY_OFF = ent_rdy_off(REG_AW);

  logic [ENT_W-1:0]  ent;
  logic [REG_AW-1:0] ent_rd;

  // Scan oldest to youngest so the lowest matching stage is the last writer.
  always_comb begin
    hit      = 1'b0;
    stage    = '0;
    ready_at = '0;
    ent      = '0;
    ent_rd   = '0;
    for (int s = STAGES - 1; s >= 0; s--) begin
      ent    = entries[s*ENT_W +: ENT_W];
      ent_rd = ent[ENT_RD_OFF +: REG_AW];
      if ((s >= FIRST) && ent[ENT_V_OFF] && ent[ENT_WR_OFF] &&
          (ent_rd != '0) && (ent_rd == rs)) begin
        hit      = 1'b1;
        stage    = STG_W'(s);
        ready_at = ent[RDY_OFF +: STG_W];
      end
    end
  end

endmodule

// File: rtl/pipeline_scoreboard.sv
// In-order pipeline hazard and forwarding unit: tracks in-flight destinations
// per stage and derives load-use stalls, branch flushes and Execute forwarding.
module pipeline_scoreboard
  import pipeline_scoreboard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int STAGES = 3,
  parameter int STG_W  = $clog2(STAGES),
  parameter int CNT_W  = 32
) (
  input logic                  clk,
  input logic                  reset,
  pipeline_scoreboard_if.slave sb
);

  localparam int ENT_W   = ent_w(REG_AW, STG_W);
  localparam int RDY_OFF = ent_rdy_off(REG_AW);

  logic [STAGES-1:0]             v_q, v_d;
  logic [STAGES-1:0]             wr_q, wr_d;
  logic [STAGES-1:0][REG_AW-1:0] rd_q, rd_d;
  logic [STAGES-1:0][STG_W-1:0]  rdy_q, rdy_d;
  logic [REG_AW-1:0]             src1_q, src1_d;
  logic [REG_AW-1:0]             src2_q, src2_d;
  logic                          hazard_q, hazard_d;
  logic [CNT_W-1:0]              count_q, count_d;

  logic [STAGES*ENT_W-1:0] entries;
  logic                    hit_da, hit_db, hit_ea, hit_eb;
  logic [STG_W-1:0]        stg_da, stg_db, stg_ea, stg_eb;
  logic [STG_W-1:0]        rdy_da, rdy_db, rdy_ea, rdy_eb;
  logic [STG_W-1:0]        rdy_in;
  logic                    lu, haz_now, bubble;
  ctl_mode_e               mode;

  // A zero ready stage still needs one cycle; anything past Writeback is Writeback.
  function automatic logic [STG_W-1:0] clamp_ready(input logic [STG_W-1:0] r);
    if (r == '0) return STG_W'(ALU_READY);
    if (int'(r) > STAGES - 1) return STG_W'(STAGES - 1);
    return r;
  endfunction

  always_comb begin
    entries = '0;
    for (int s = 0; s < STAGES; s++) begin
      entries[s*ENT_W + ENT_V_OFF]         = v_q[s];
      entries[s*ENT_W + ENT_WR_OFF]        = wr_q[s];
      entries[s*ENT_W + ENT_RD_OFF +: REG_AW] = rd_q[s];
      entries[s*ENT_W + RDY_OFF +: STG_W]  = rdy_q[s];
    end
  end

  pipeline_scoreboard_match #(.REG_AW(REG_AW), .STAGES(STAGES), .STG_W(STG_W), .FIRST(0))
    u_match_da (.rs(sb.rs1_d), .entries(entries), .hit(hit_da), .stage(stg_da), .ready_at(rdy_da));
  pipeline_scoreboard_match #(.REG_AW(REG_AW), .STAGES(STAGES), .STG_W(STG_W), .FIRST(0))
    u_match_db (.rs(sb.rs2_d), .entries(entries), .hit(hit_db), .stage(stg_db), .ready_at(rdy_db));
  // Execute consumers skip stage 0, which holds the consumer itself.
  pipeline_scoreboard_match #(.REG_AW(REG_AW), .STAGES(STAGES), .STG_W(STG_W), .FIRST(1))
    u_match_ea (.rs(src1_q), .entries(entries), .hit(hit_ea), .stage(stg_ea), .ready_at(rdy_ea));
  pipeline_scoreboard_match #(.REG_AW(REG_AW), .STAGES(STAGES), .STG_W(STG_W), .FIRST(1))
    u_match_eb (.rs(src2_q), .entries(entries), .hit(hit_eb), .stage(stg_eb), .ready_at(rdy_eb));

  always_comb begin
    rdy_in  = clamp_ready(sb.ready_at_d);
    lu      = sb.issue_valid_d &&
              ((hit_da && (int'(stg_da) + 1 < int'(rdy_da))) ||
               (hit_db && (int'(stg_db) + 1 < int'(rdy_db))));
    haz_now = v_q[0] && ((hit_ea && (stg_ea < rdy_ea)) ||
                         (hit_eb && (stg_eb < rdy_eb)));

    if (!reset)                 mode = CTL_NORMAL;
    else if (sb.hold)           mode = CTL_HOLD;
    else if (sb.branch_taken_e) mode = CTL_BRANCH;
    else if (lu)                mode = CTL_LU;
    else                        mode = CTL_NORMAL;

    bubble      = (mode == CTL_BRANCH) || (mode == CTL_LU);
    sb.stall_f  = (mode == CTL_HOLD) || (mode == CTL_LU);
    sb.stall_d  = (mode == CTL_HOLD) || (mode == CTL_LU);
    sb.flush_d  = (mode == CTL_BRANCH);
    sb.bubble_e = bubble;

    sb.fwd_a_e = (v_q[0] && hit_ea && (stg_ea >= rdy_ea)) ? stg_ea : STG_W'(FWD_RF);
    sb.fwd_b_e = (v_q[0] && hit_eb && (stg_eb >= rdy_eb)) ? stg_eb : STG_W'(FWD_RF);
    sb.hazard_error = hazard_q;
    sb.stall_count  = count_q;
  end

  always_comb begin
    v_d      = v_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    rdy_d    = rdy_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    hazard_d = hazard_q;
    count_d  = count_q;
    if (mode != CTL_HOLD) begin
      for (int s = STAGES - 1; s >= 1; s--) begin
        v_d[s]   = v_q[s-1];
        wr_d[s]  = wr_q[s-1];
        rd_d[s]  = rd_q[s-1];
        rdy_d[s] = rdy_q[s-1];
      end
      v_d[0]   = sb.issue_valid_d && !bubble;
      wr_d[0]  = sb.reg_write_d;
      rd_d[0]  = sb.rd_d;
      rdy_d[0] = rdy_in;
      src1_d   = sb.rs1_d;
      src2_d   = sb.rs2_d;
      hazard_d = hazard_q || haz_now;
      if ((mode == CTL_LU) && (count_q != {CNT_W{1'b1}}))
        count_d = count_q + CNT_W'(1);
    end
  end

  // Control state: cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_q      <= '0;
      hazard_q <= 1'b0;
      count_q  <= '0;
    end else begin
      v_q      <= v_d;
      hazard_q <= hazard_d;
      count_q  <= count_d;
    end
  end

  // Entry payload: meaningless while v is clear, so left unreset.
  always_ff @(posedge clk) begin
    wr_q   <= wr_d;
    rd_q   <= rd_d;
    rdy_q  <= rdy_d;
    src1_q <= src1_d;
    src2_q <= src2_d;
  end

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Directed bench for pipeline_scoreboard: a 3-stage and a 5-stage instance
// driven by a linear sequence of instructions with hand-computed expectations.
module tb_pipeline_scoreboard;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pipeline_scoreboard_if #(.REG_AW(5), .STG_W(2), .CNT_W(32)) if3 ();
  pipeline_scoreboard_if #(.REG_AW(5), .STG_W(3), .CNT_W(32)) if5 ();

  pipeline_scoreboard #(.REG_AW(5), .STAGES(3), .STG_W(2), .CNT_W(32))
    dut3 (.clk(clk), .reset(reset), .sb(if3.slave));
  pipeline_scoreboard #(.REG_AW(5), .STAGES(5), .STG_W(3), .CNT_W(32))
    dut5 (.clk(clk), .reset(reset), .sb(if5.slave));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ctl3();
    return {if3.stall_f, if3.stall_d, if3.flush_d, if3.bubble_e};
  endfunction

  function automatic logic [3:0] ctl5();
    return {if5.stall_f, if5.stall_d, if5.flush_d, if5.bubble_e};
  endfunction

  task automatic d3(input logic vld, input logic [4:0] rs1, input logic [4:0] rs2,
                    input logic [4:0] rd, input logic wr, input logic [1:0] rdy);
    if3.issue_valid_d = vld;
    if3.rs1_d = rs1;
    if3.rs2_d = rs2;
    if3.rd_d = rd;
    if3.reg_write_d = wr;
    if3.ready_at_d = rdy;
  endtask

  task automatic d5(input logic vld, input logic [4:0] rs1, input logic [4:0] rs2,
                    input logic [4:0] rd, input logic wr, input logic [2:0] rdy);
    if5.issue_valid_d = vld;
    if5.rs1_d = rs1;
    if5.rs2_d = rs2;
    if5.rd_d = rd;
    if5.reg_write_d = wr;
    if5.ready_at_d = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain3();
    d3(0, 0, 0, 0, 0, 0);
    repeat (4) tick();
  endtask

  initial begin
    d3(0, 0, 0, 0, 0, 0);
    d5(0, 0, 0, 0, 0, 0);
    if3.branch_taken_e = 0; if3.hold = 0;
    if5.branch_taken_e = 0; if5.hold = 0;
    repeat (2) tick();
    chk("rst_ctl3", 64'(ctl3()), 64'd0);
    chk("rst_fwd3", 64'({if3.fwd_a_e, if3.fwd_b_e}), 64'd0);
    chk("rst_cnt3", 64'(if3.stall_count), 64'd0);
    chk("rst_haz3", 64'(if3.hazard_error), 64'd0);
    chk("rst_ctl5", 64'(ctl5()), 64'd0);
    reset = 1'b1;
    tick();

    // ALU chain: add x5; add x6,x5,x1
    d3(1, 0, 0, 5, 1, 1); #1;
    chk("alu_prod_ctl", 64'(ctl3()), 64'd0);
    tick();
    d3(1, 5, 1, 6, 1, 1); #1;
    chk("alu_nostall", 64'(ctl3()), 64'd0);
    tick();
    d3(0, 0, 0, 0, 0, 0); #1;
    chk("alu_fwd_a", 64'(if3.fwd_a_e), 64'd1);
    chk("alu_fwd_b", 64'(if3.fwd_b_e), 64'd0);
    drain3();

    // Load-use: lw x6; sub x7,x6,x6
    d3(1, 0, 0, 6, 1, 2); tick();
    d3(1, 6, 6, 7, 1, 1); #1;
    chk("lu_ctl", 64'(ctl3()), 64'b1101);
    tick();
    chk("lu_release_ctl", 64'(ctl3()), 64'd0);
    chk("lu_count", 64'(if3.stall_count), 64'd1);
    tick();
    d3(0, 0, 0, 0, 0, 0); #1;
    chk("lu_fwd_a", 64'(if3.fwd_a_e), 64'd2);
    chk("lu_fwd_b", 64'(if3.fwd_b_e), 64'd2);
    chk("lu_haz", 64'(if3.hazard_error), 64'd0);
    drain3();

    // Youngest wins: lw x7 then add x7, then consumer of x7
    d3(1, 0, 0, 7, 1, 2); tick();
    d3(1, 0, 0, 7, 1, 1); tick();
    d3(1, 7, 0, 8, 1, 1); #1;
    chk("young_ctl", 64'(ctl3()), 64'd0);
    tick();
    d3(0, 0, 0, 0, 0, 0); #1;
    chk("young_fwd_a", 64'(if3.fwd_a_e), 64'd1);
    drain3();

    // x0 producer never creates a dependency
    d3(1, 0, 0, 0, 1, 2); tick();
    d3(1, 0, 0, 9, 1, 1); #1;
    chk("x0_ctl", 64'(ctl3()), 64'd0);
    tick();
    d3(0, 0, 0, 0, 0, 0); #1;
    chk("x0_fwd", 64'({if3.fwd_a_e, if3.fwd_b_e}), 64'd0);
    drain3();

    // Branch wins over load-use
    d3(1, 0, 0, 6, 1, 2); tick();
    d3(1, 6, 0, 7, 1, 1); if3.branch_taken_e = 1; #1;
    chk("br_ctl", 64'(ctl3()), 64'b0011);
    tick();
    if3.branch_taken_e = 0; d3(0, 0, 0, 0, 0, 0); #1;
    chk("br_count", 64'(if3.stall_count), 64'd1);
    chk("br_fwd", 64'(if3.fwd_a_e), 64'd0);
    drain3();

    // Hold freezes lw x9 in stage 0 for three cycles
    d3(1, 0, 0, 9, 1, 2); tick();
    d3(1, 9, 0, 10, 1, 1); if3.hold = 1; #1;
    chk("hold_ctl", 64'(ctl3()), 64'b1100);
    repeat (3) tick();
    chk("hold_count", 64'(if3.stall_count), 64'd1);
    if3.hold = 0; #1;
    chk("hold_rel_lu", 64'(ctl3()), 64'b1101);
    tick();
    chk("hold_once_ctl", 64'(ctl3()), 64'd0);
    chk("hold_once_cnt", 64'(if3.stall_count), 64'd2);
    tick();
    d3(0, 0, 0, 0, 0, 0); #1;
    chk("hold_fwd_a", 64'(if3.fwd_a_e), 64'd2);
    drain3();

    // ready_at 0 behaves as ALU
    d3(1, 0, 0, 11, 1, 0); tick();
    d3(1, 11, 0, 12, 1, 1); #1;
    chk("rdy0_ctl", 64'(ctl3()), 64'd0);
    tick();
    d3(0, 0, 0, 0, 0, 0); #1;
    chk("rdy0_fwd", 64'(if3.fwd_a_e), 64'd1);
    drain3();

    // ready_at 3 clamps to Writeback (2) on a 3-stage tracker
    d3(1, 0, 0, 13, 1, 3); tick();
    d3(1, 0, 13, 14, 1, 1); #1;
    chk("clamp_ctl", 64'(ctl3()), 64'b1101);
    tick();
    chk("clamp_rel", 64'(ctl3()), 64'd0);
    chk("clamp_cnt", 64'(if3.stall_count), 64'd3);
    tick();
    d3(0, 0, 0, 0, 0, 0); #1;
    chk("clamp_fwd_b", 64'(if3.fwd_b_e), 64'd2);
    drain3();

    // No stall without a real Decode instruction
    d3(1, 0, 0, 6, 1, 2); tick();
    d3(0, 6, 6, 7, 1, 1); #1;
    chk("novalid_ctl", 64'(ctl3()), 64'd0);
    drain3();

    // Asynchronous reset during a load-use stall, with hold also raised
    d3(1, 0, 0, 6, 1, 2); tick();
    d3(1, 6, 0, 7, 1, 1); #1;
    chk("rstlu_pre", 64'(ctl3()), 64'b1101);
    if3.hold = 1; reset = 1'b0; #1;
    chk("rstlu_ctl", 64'(ctl3()), 64'd0);
    chk("rstlu_cnt", 64'(if3.stall_count), 64'd0);
    chk("rstlu_haz", 64'(if3.hazard_error), 64'd0);
    tick();
    if3.hold = 0; d3(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    tick();

    // 5-stage tracker: ready_at 4 producer then dependent consumer
    d5(1, 0, 0, 20, 1, 4); tick();
    d5(1, 20, 0, 21, 1, 1); #1;
    chk("s5_stall1", 64'(ctl5()), 64'b1101);
    tick();
    chk("s5_stall2", 64'(ctl5()), 64'b1101);
    tick();
    chk("s5_stall3", 64'(ctl5()), 64'b1101);
    tick();
    chk("s5_release", 64'(ctl5()), 64'd0);
    chk("s5_count", 64'(if5.stall_count), 64'd3);
    tick();
    d5(0, 0, 0, 0, 0, 0); #1;
    chk("s5_fwd_a", 64'(if5.fwd_a_e), 64'd4);
    chk("s5_haz", 64'(if5.hazard_error), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
